// File: rtl/cb_sw_alloc_if.sv
// Request/grant bundle between the route-compute/VC stage and the switch allocator.
// timeout_o is present only when SA_TIMEOUT_EN is defined.
interface cb_sw_alloc_if #(
  parameter int NPORT = 5,
  parameter int PORTW = 3
);
  logic [NPORT-1:0]       req_i;
  logic [NPORT*PORTW-1:0] port_i;
  logic [NPORT-1:0]       ivalid_i;
  logic [NPORT-1:0]       itail_i;
  logic [NPORT-1:0]       oready_i;
  logic [NPORT-1:0]       grt_o;
  logic [NPORT*NPORT-1:0] sel_o;
  logic [NPORT-1:0]       busy_o;
`ifdef SA_TIMEOUT_EN
  logic [NPORT-1:0]       timeout_o;
`endif

  modport master (
    output req_i, port_i, ivalid_i, itail_i, oready_i,
    input  grt_o, sel_o, busy_o
`ifdef SA_TIMEOUT_EN
    , input timeout_o
`endif
  );

  modport slave (
    input  req_i, port_i, ivalid_i, itail_i, oready_i,
    output grt_o, sel_o, busy_o
`ifdef SA_TIMEOUT_EN
    , output timeout_o
`endif
  );
endinterface

// File: rtl/cb_sw_alloc.sv
// Switch allocator for the 5x5 router crossbar: per-output round-robin lock held until tail.
// Optional feature macro SA_TIMEOUT_EN adds a forced release after TIMEOUT idle owner cycles.
module cb_sw_alloc #(
  parameter int NPORT = 5,
  parameter int PORTW = 3
`ifdef SA_TIMEOUT_EN
  , parameter int TIMEOUT = 16
`endif
) (
  input logic          clk,
  input logic          rst_,
  cb_sw_alloc_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  logic [NPORT-1:0] sel_arr [NPORT];
  logic [NPORT-1:0] owns;

  // Select fields are one-hot per output, so OR-ing them gives the set of owning inputs.
  always_comb begin
    owns = '0;
    for (int j = 0; j < NPORT; j++) begin
      owns = owns | sel_arr[j];
    end
  end

  assign bus.grt_o = owns;

  for (genvar gi = 0; gi < NPORT; gi++) begin : g_out
    state_t           state_reg;
    logic [PORTW-1:0] own_reg;
    logic [PORTW-1:0] ptr_reg;
    logic [PORTW-1:0] ptr_next;
    logic [PORTW-1:0] pick;
    logic [NPORT-1:0] sel_reg;
    logic [NPORT-1:0] cand;
    logic             found;
    logic             tail_rel;
    logic             drop_rel;
    logic             expire;
    int               idx;

    for (genvar gk = 0; gk < NPORT; gk++) begin : g_cand
      assign cand[gk] = bus.req_i[gk] && !owns[gk] &&
                        (bus.port_i[gk*PORTW +: PORTW] == PORTW'(gi));
    end

    // Round-robin scan starting at ptr_reg, wrapping modulo NPORT.
    always_comb begin
      pick  = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < NPORT; k++) begin
        idx = int'(ptr_reg) + k;
        if (idx >= NPORT) begin
          idx = idx - NPORT;
        end
        if (!found && cand[idx]) begin
          found = 1'b1;
          pick  = PORTW'(idx);
        end
      end
    end

    assign ptr_next = (own_reg == PORTW'(NPORT-1)) ? '0 : own_reg + PORTW'(1);
    assign tail_rel = bus.ivalid_i[own_reg] & bus.itail_i[own_reg] & bus.oready_i[gi];
    assign drop_rel = ~bus.req_i[own_reg];

`ifdef SA_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_reg;
    logic          tout_reg;

    // Expires on the edge where this idle cycle would bring the count to TIMEOUT.
    assign expire = !bus.ivalid_i[own_reg] && (cnt_reg == CW'(TIMEOUT - 1));
    assign bus.timeout_o[gi] = tout_reg;
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
        state_reg <= IDLE;
        own_reg   <= '0;
        ptr_reg   <= '0;
        sel_reg   <= '0;
`ifdef SA_TIMEOUT_EN
        cnt_reg   <= '0;
        tout_reg  <= 1'b0;
`endif
      end else begin
`ifdef SA_TIMEOUT_EN
        tout_reg <= 1'b0;
`endif
        case (state_reg)
          IDLE: begin
            if (found) begin
              state_reg <= LOCKED;
              own_reg   <= pick;
              sel_reg   <= NPORT'(1) << pick;
            end
          end
          LOCKED: begin
            if (tail_rel || drop_rel || expire) begin
              state_reg <= IDLE;
              sel_reg   <= '0;
              ptr_reg   <= ptr_next;
`ifdef SA_TIMEOUT_EN
              cnt_reg   <= '0;
              tout_reg  <= !(tail_rel || drop_rel);
`endif
            end
`ifdef SA_TIMEOUT_EN
            else if (bus.ivalid_i[own_reg]) begin
              cnt_reg <= '0;
            end else begin
              cnt_reg <= cnt_reg + CW'(1);
            end
`endif
          end
          default: state_reg <= IDLE;
        endcase
      end
    end

    assign sel_arr[gi]                   = sel_reg;
    assign bus.sel_o[gi*NPORT +: NPORT]  = sel_reg;
    assign bus.busy_o[gi]                = (state_reg == LOCKED);
  end
endmodule

// File: tb/tb_cb_sw_alloc.sv
// Scoreboard bench for cb_sw_alloc: directed scenarios then random traffic vs. a behavioural model.
// Build with SA_TIMEOUT_EN defined to also exercise the forced-release path (TIMEOUT=4 here).
module tb_cb_sw_alloc;
  localparam int NPORT = 5;
  localparam int PORTW = 3;
`ifdef SA_TIMEOUT_EN
  localparam int TIMEOUT = 4;
`endif

  logic clk  = 1'b0;
  logic rst_ = 1'b0;
  always #5 clk = ~clk;

  cb_sw_alloc_if #(.NPORT(NPORT), .PORTW(PORTW)) bus ();

  cb_sw_alloc #(
    .NPORT(NPORT),
    .PORTW(PORTW)
`ifdef SA_TIMEOUT_EN
    , .TIMEOUT(TIMEOUT)
`endif
  ) dut (
    .clk (clk),
    .rst_(rst_),
    .bus (bus)
  );

  typedef struct packed {
    logic [NPORT*NPORT-1:0] sel;
    logic [NPORT-1:0]       busy;
    logic [NPORT-1:0]       grt;
    logic [NPORT-1:0]       tout;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // stimulus for the next edge
  logic             rst_v;
  logic [NPORT-1:0] req_v, ivalid_v, itail_v, oready_v;
  int               port_v [NPORT];

  // behavioural model: owner of each output (-1 = free) and round-robin start
  int               own_m [NPORT];
  int               ptr_m [NPORT];
  logic [NPORT-1:0] tout_m;
`ifdef SA_TIMEOUT_EN
  int               tcnt_m [NPORT];
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model_outputs();
    exp_t e;
    e      = '0;
    e.tout = tout_m;
    for (int j = 0; j < NPORT; j++) begin
      if (own_m[j] >= 0) begin
        e.sel[j*NPORT + own_m[j]] = 1'b1;
        e.busy[j]                 = 1'b1;
        e.grt[own_m[j]]           = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic model_edge();
    int  own_old [NPORT];
    bit  owning  [NPORT];
    int  o, best, bestd, d;
    bit  rel, to;
    tout_m = '0;
    if (!rst_v) begin
      for (int j = 0; j < NPORT; j++) begin
        own_m[j] = -1;
        ptr_m[j] = 0;
`ifdef SA_TIMEOUT_EN
        tcnt_m[j] = 0;
`endif
      end
      return;
    end
    own_old = own_m;
    for (int i = 0; i < NPORT; i++) owning[i] = 1'b0;
    for (int j = 0; j < NPORT; j++) if (own_old[j] >= 0) owning[own_old[j]] = 1'b1;
    for (int j = 0; j < NPORT; j++) begin
      if (own_old[j] >= 0) begin
        o   = own_old[j];
        rel = !req_v[o] || (ivalid_v[o] && itail_v[o] && oready_v[j]);
        to  = 1'b0;
`ifdef SA_TIMEOUT_EN
        if (!rel) begin
          if (ivalid_v[o]) tcnt_m[j] = 0;
          else begin
            tcnt_m[j]++;
            if (tcnt_m[j] == TIMEOUT) begin
              to  = 1'b1;
              rel = 1'b1;
            end
          end
        end
        if (rel) tcnt_m[j] = 0;
`endif
        if (rel) begin
          own_m[j]  = -1;
          ptr_m[j]  = (o + 1) % NPORT;
          tout_m[j] = to;
        end
      end else begin
        best  = -1;
        bestd = NPORT;
        for (int i = 0; i < NPORT; i++) begin
          if (req_v[i] && port_v[i] == j && !owning[i]) begin
            d = (i - ptr_m[j] + NPORT) % NPORT;
            if (d < bestd) begin
              bestd = d;
              best  = i;
            end
          end
        end
        own_m[j] = best;
      end
    end
  endtask

  task automatic apply();
    rst_          = rst_v;
    bus.req_i     = req_v;
    bus.ivalid_i  = ivalid_v;
    bus.itail_i   = itail_v;
    bus.oready_i  = oready_v;
    for (int i = 0; i < NPORT; i++) bus.port_i[i*PORTW +: PORTW] = PORTW'(port_v[i]);
  endtask

  // Drive one cycle: inputs settle mid-cycle, expectation for the next edge goes to the scoreboard.
  task automatic step();
    apply();
    model_edge();
    sb_q.push_back(model_outputs());
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_v    = '0;
    ivalid_v = '0;
    itail_v  = '0;
    oready_v = '1;
    for (int i = 0; i < NPORT; i++) port_v[i] = 0;
  endtask

  task automatic rand_cycle();
    int mine;
    for (int i = 0; i < NPORT; i++) begin
      mine = -1;
      for (int j = 0; j < NPORT; j++) if (own_m[j] == i) mine = j;
      if (!req_v[i]) begin
        if ($urandom_range(0, 3) == 0) begin
          req_v[i]  = 1'b1;
          port_v[i] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
        end
      end else if ($urandom_range(0, 24) == 0) begin
        req_v[i] = 1'b0;
      end else if (mine >= 0 && $urandom_range(0, 7) == 0) begin
        port_v[i] = int'($urandom_range(0, 7));
      end
      ivalid_v[i] = ($urandom_range(0, 3) != 0);
      itail_v[i]  = ($urandom_range(0, 3) == 0);
      oready_v[i] = ($urandom_range(0, 4) != 0);
    end
  endtask

  // Monitor: outputs are sampled 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        logic       ok;
        logic [NPORT-1:0] seen;
        mon_e = sb_q.pop_front();
        check("sb_sel",  32'(bus.sel_o),  32'(mon_e.sel));
        check("sb_busy", 32'(bus.busy_o), 32'(mon_e.busy));
        check("sb_grt",  32'(bus.grt_o),  32'(mon_e.grt));
`ifdef SA_TIMEOUT_EN
        check("sb_timeout", 32'(bus.timeout_o), 32'(mon_e.tout));
`endif
        ok   = 1'b1;
        seen = '0;
        for (int j = 0; j < NPORT; j++) begin
          if (!$onehot0(bus.sel_o[j*NPORT +: NPORT])) ok = 1'b0;
          if ((seen & bus.sel_o[j*NPORT +: NPORT]) != '0) ok = 1'b0;
          seen = seen | bus.sel_o[j*NPORT +: NPORT];
        end
        check("sel_invariant", 32'(ok), 32'd1);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int j = 0; j < NPORT; j++) begin
      own_m[j] = -1;
      ptr_m[j] = 0;
`ifdef SA_TIMEOUT_EN
      tcnt_m[j] = 0;
`endif
    end
    tout_m = '0;
    idle_inputs();
    rst_v = 1'b0;
    req_v = 5'h1F;
    apply();
    @(negedge clk);
    #1;

    // reset held with every input requesting
    check("rst_sel",  32'(bus.sel_o),  32'd0);
    check("rst_grt",  32'(bus.grt_o),  32'd0);
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    step();
    step();
    rst_v = 1'b1;
    rst_  = 1'b1;
    #1;
    check("post_rst_sel", 32'(bus.sel_o), 32'd0);
    check("post_rst_grt", 32'(bus.grt_o), 32'd0);
    step();
    check("first_grant_sel0", 32'(bus.sel_o[0 +: NPORT]), 32'b00001);
    idle_inputs();
    step();
    step();

    // single path 0 -> 2
    req_v[0] = 1'b1; port_v[0] = 2;
    step();
    check("single_sel2", 32'(bus.sel_o[10 +: NPORT]), 32'b00001);
    check("single_grt",  32'(bus.grt_o), 32'b00001);
    ivalid_v[0] = 1'b1;
    step();
    step();
    itail_v[0] = 1'b1;
    step();
    check("single_rel_busy2", 32'(bus.busy_o[2]), 32'd0);
    check("single_rel_sel",   32'(bus.sel_o), 32'd0);
    idle_inputs();
    step();

    // contention on port 4 between inputs 1 and 3
    req_v = 5'b01010; port_v[1] = 4; port_v[3] = 4;
    step();
    check("cont_first_sel4", 32'(bus.sel_o[20 +: NPORT]), 32'b00010);
    ivalid_v[1] = 1'b1; itail_v[1] = 1'b1;
    step();
    check("cont_bubble_busy4", 32'(bus.busy_o[4]), 32'd0);
    req_v[1] = 1'b0; ivalid_v = '0; itail_v = '0;
    step();
    check("cont_second_sel4", 32'(bus.sel_o[20 +: NPORT]), 32'b01000);
    ivalid_v[3] = 1'b1; itail_v[3] = 1'b1;
    step();
    idle_inputs();
    step();
    req_v = 5'b01010; port_v[1] = 4; port_v[3] = 4;
    step();
    step();
    idle_inputs();
    step();

    // parallel grants 0 -> 2 and 3 -> 3
    req_v = 5'b01001; port_v[0] = 2; port_v[3] = 3;
    step();
    check("par_sel2", 32'(bus.sel_o[10 +: NPORT]), 32'b00001);
    check("par_sel3", 32'(bus.sel_o[15 +: NPORT]), 32'b01000);
    check("par_grt",  32'(bus.grt_o), 32'b01001);
    idle_inputs();
    step();

    // backpressure: tail stalls on port 1 for three cycles
    req_v[0] = 1'b1; port_v[0] = 1;
    step();
    ivalid_v[0] = 1'b1; itail_v[0] = 1'b1; oready_v[1] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check("bp_hold_busy1", 32'(bus.busy_o[1]), 32'd1);
    end
    oready_v[1] = 1'b1;
    step();
    check("bp_rel_busy1", 32'(bus.busy_o[1]), 32'd0);
    idle_inputs();
    step();

`ifdef SA_TIMEOUT_EN
    // idle owner 2 on port 0 is forced off after TIMEOUT cycles
    req_v[2] = 1'b1; port_v[2] = 0;
    step();
    for (int c = 0; c < TIMEOUT; c++) step();
    check("to_pulse0", 32'(bus.timeout_o[0]), 32'd1);
    check("to_busy0",  32'(bus.busy_o[0]), 32'd0);
    idle_inputs();
    step();
`endif

    // random traffic with one reset in the middle
    for (int c = 0; c < 1500; c++) begin
      rand_cycle();
      rst_v = !(c == 700 || c == 701);
      step();
    end
    rst_v = 1'b1;
    idle_inputs();
    step();
    step();

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
